// File: rtl/led_pio_sequencer.sv
// led_pio_sequencer
//   Autonomous LED pattern engine. Owns the LED PIO slave and writes it as an
//   Avalon-MM write-only master with static, rotating, bouncing or blinking
//   patterns, advancing once every PERIOD clocks. The CPU configures it through
//   a four-register Avalon-MM slave.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   cfg_address         config register select (0 CTRL, 1 PERIOD, 2 PATTERN, 3 STATUS)
//   cfg_chipselect      config slave select
//   cfg_write_n         active-low config write strobe
//   cfg_writedata       config write data
//   cfg_readdata        config read data, combinational (zero wait states)
//   pio_address         LED PIO register address, always 0
//   pio_chipselect      registered PIO write strobe
//   pio_write_n         inverse of pio_chipselect
//   pio_writedata       {zeros, current pattern}
//   running             high while the sequencer is loading or running
module led_pio_sequencer #(
   parameter int unsigned         LED_WIDTH    = 10,
   parameter int unsigned         PERIOD_W     = 24,
   parameter logic [PERIOD_W-1:0] RESET_PERIOD = 24'd5000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  cfg_address,
   input  logic        cfg_chipselect,
   input  logic        cfg_write_n,
   input  logic [31:0] cfg_writedata,
   output logic [31:0] cfg_readdata,
   output logic [1:0]  pio_address,
   output logic        pio_chipselect,
   output logic        pio_write_n,
   output logic [31:0] pio_writedata,
   output logic        running
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StRun  = 2'd2;

   localparam logic [1:0] ModeStatic = 2'd0;
   localparam logic [1:0] ModeRotate = 2'd1;
   localparam logic [1:0] ModeBounce = 2'd2;
   localparam logic [1:0] ModeBlink  = 2'd3;

   localparam logic [PERIOD_W-1:0]  PERIOD_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
   localparam logic [LED_WIDTH-1:0] PATTERN_RST = {{(LED_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]           state_q, state_d;
   logic                 en_q, en_d;
   logic [1:0]           mode_q, mode_d;
   logic [PERIOD_W-1:0]  period_q, period_d;
   logic [LED_WIDTH-1:0] pattern_q, pattern_d;
   logic [LED_WIDTH-1:0] cur_q, cur_d;
   logic                 dir_q, dir_d;
   logic                 phase_q, phase_d;
   logic [PERIOD_W-1:0]  presc_q, presc_d;
   logic                 pio_cs_q, pio_cs_d;

   logic                 cfg_wr;
   logic                 wr_ctrl, wr_period, wr_pattern;
   logic                 start, stop, tick;
   logic [PERIOD_W-1:0]  period_m1;
   logic [LED_WIDTH-1:0] adv_pattern;
   logic                 adv_dir, adv_phase;
   logic                 unused_wdata;

   // Only the low bits of the write data are decoded.
   assign unused_wdata = ^cfg_writedata;

   assign cfg_wr     = cfg_chipselect & ~cfg_write_n;
   assign wr_ctrl    = cfg_wr && (cfg_address == 2'd0);
   assign wr_period  = cfg_wr && (cfg_address == 2'd1);
   assign wr_pattern = cfg_wr && (cfg_address == 2'd2);

   // PERIOD of zero behaves like one.
   assign period_m1 = (period_q == '0) ? '0 : period_q - PERIOD_ONE;
   assign tick      = (state_q != StIdle) && (presc_q == period_m1);

   // Any write of EN=1 (re)starts; while active, PERIOD/PATTERN writes restart too.
   assign start = (wr_ctrl && cfg_writedata[0]) ||
                  ((state_q != StIdle) && (wr_period || wr_pattern));
   assign stop  = (state_q != StIdle) && wr_ctrl && !cfg_writedata[0];

   // Register file
   always_comb begin
      en_d      = en_q;
      mode_d    = mode_q;
      period_d  = period_q;
      pattern_d = pattern_q;
      if (wr_ctrl) begin
         en_d   = cfg_writedata[0];
         mode_d = cfg_writedata[2:1];
      end
      if (wr_period) begin
         period_d = cfg_writedata[PERIOD_W-1:0];
      end
      if (wr_pattern) begin
         pattern_d = cfg_writedata[LED_WIDTH-1:0];
      end
   end

   // Next pattern on a tick
   always_comb begin
      adv_pattern = cur_q;
      adv_dir     = dir_q;
      adv_phase   = phase_q;
      unique case (mode_q)
         ModeStatic: adv_pattern = cur_q;
         ModeRotate: adv_pattern = {cur_q[LED_WIDTH-2:0], cur_q[LED_WIDTH-1]};
         ModeBounce: begin
            if (cur_q == '0) begin
               // Pattern shifted out entirely; start over from PATTERN.
               adv_pattern = pattern_q;
            end else if (!dir_q) begin
               adv_pattern = cur_q << 1;
               if (adv_pattern[LED_WIDTH-1]) adv_dir = 1'b1;
            end else begin
               adv_pattern = cur_q >> 1;
               if (adv_pattern[0]) adv_dir = 1'b0;
            end
         end
         ModeBlink: begin
            adv_phase   = ~phase_q;
            adv_pattern = adv_phase ? '0 : pattern_q;
         end
         default: adv_pattern = cur_q;
      endcase
   end

   // Sequencer FSM; a config write on a tick edge wins and drops the tick.
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      dir_d    = dir_q;
      phase_d  = phase_q;
      presc_d  = presc_q;
      pio_cs_d = 1'b0;
      if (start) begin
         state_d  = StLoad;
         cur_d    = pattern_d;
         dir_d    = 1'b0;
         phase_d  = 1'b0;
         presc_d  = '0;
         pio_cs_d = 1'b1;
      end else if (stop) begin
         state_d = StIdle;
      end else if (state_q != StIdle) begin
         state_d = StRun;
         // The LOAD cycle counts as the first cycle of the period.
         if (tick) begin
            presc_d  = '0;
            cur_d    = adv_pattern;
            dir_d    = adv_dir;
            phase_d  = adv_phase;
            pio_cs_d = 1'b1;
         end else begin
            presc_d = presc_q + PERIOD_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         en_q      <= 1'b0;
         mode_q    <= ModeStatic;
         period_q  <= RESET_PERIOD;
         pattern_q <= PATTERN_RST;
         cur_q     <= '0;
         dir_q     <= 1'b0;
         phase_q   <= 1'b0;
         presc_q   <= '0;
         pio_cs_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         mode_q    <= mode_d;
         period_q  <= period_d;
         pattern_q <= pattern_d;
         cur_q     <= cur_d;
         dir_q     <= dir_d;
         phase_q   <= phase_d;
         presc_q   <= presc_d;
         pio_cs_q  <= pio_cs_d;
      end
   end

   assign running        = (state_q != StIdle);
   assign pio_address    = 2'b00;
   assign pio_chipselect = pio_cs_q;
   assign pio_write_n    = ~pio_cs_q;
   // cur_pattern only changes alongside a strobe, so it doubles as the write data.
   assign pio_writedata  = {{(32-LED_WIDTH){1'b0}}, cur_q};

   always_comb begin
      cfg_readdata = '0;
      unique case (cfg_address)
         2'd0: cfg_readdata[2:0] = {mode_q, en_q};
         2'd1: cfg_readdata[PERIOD_W-1:0] = period_q;
         2'd2: cfg_readdata[LED_WIDTH-1:0] = pattern_q;
         2'd3: begin
            cfg_readdata[0]               = running;
            cfg_readdata[1]               = dir_q;
            cfg_readdata[2]               = phase_q;
            cfg_readdata[16 +: LED_WIDTH] = cur_q;
         end
         default: cfg_readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_led_pio_sequencer.sv
`timescale 1ns/1ps
module tb_led_pio_sequencer;

   localparam int LW = 10;
   localparam int PW = 24;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  cfg_address = 2'd0;
   logic        cfg_chipselect = 1'b0;
   logic        cfg_write_n = 1'b1;
   logic [31:0] cfg_writedata = 32'd0;
   logic [31:0] cfg_readdata;
   logic [1:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;
   logic        running;

   led_pio_sequencer #(
      .LED_WIDTH(LW),
      .PERIOD_W(PW),
      .RESET_PERIOD(24'd5000000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cfg_address(cfg_address),
      .cfg_chipselect(cfg_chipselect),
      .cfg_write_n(cfg_write_n),
      .cfg_writedata(cfg_writedata),
      .cfg_readdata(cfg_readdata),
      .pio_address(pio_address),
      .pio_chipselect(pio_chipselect),
      .pio_write_n(pio_write_n),
      .pio_writedata(pio_writedata),
      .running(running)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_miss = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic          m_en, m_run, m_dir, m_phase, m_strobe;
   logic [1:0]    m_mode;
   logic [PW-1:0] m_period;
   logic [LW-1:0] m_pattern, m_leds;
   int            m_left;  // cycles until the next pattern step

   function automatic int eff_period(input logic [PW-1:0] p);
      return (p == 0) ? 1 : int'(p);
   endfunction

   function automatic logic [LW-1:0] rotl(input logic [LW-1:0] v);
      int x;
      x = int'(v) * 2;
      if (x >= (1 << LW)) x = x - (1 << LW) + 1;
      return LW'(x);
   endfunction

   task automatic mdl_reset();
      m_en = 0; m_mode = 0; m_period = 24'd5000000; m_pattern = 1; m_leds = 0;
      m_run = 0; m_dir = 0; m_phase = 0; m_strobe = 0; m_left = 0;
   endtask

   task automatic mdl_step();
      bit start, stop;
      start = 0;
      stop = 0;
      m_strobe = 0;
      if (cfg_chipselect && !cfg_write_n) begin
         case (cfg_address)
            2'd0: begin
               m_en = cfg_writedata[0];
               m_mode = cfg_writedata[2:1];
               start = m_en;
               stop = !m_en && m_run;
            end
            2'd1: begin m_period = cfg_writedata[PW-1:0]; start = m_run; end
            2'd2: begin m_pattern = cfg_writedata[LW-1:0]; start = m_run; end
            default: ;
         endcase
      end
      if (start) begin
         m_run = 1; m_leds = m_pattern; m_dir = 0; m_phase = 0;
         m_left = eff_period(m_period);
         m_strobe = 1;
      end else if (stop) begin
         m_run = 0;
      end else if (m_run) begin
         m_left--;
         if (m_left == 0) begin
            m_left = eff_period(m_period);
            m_strobe = 1;
            case (m_mode)
               2'd1: m_leds = rotl(m_leds);
               2'd2: begin
                  if (m_leds == 0) m_leds = m_pattern;
                  else if (!m_dir) begin
                     m_leds = LW'((int'(m_leds) * 2) % (1 << LW));
                     if (m_leds >= LW'(1 << (LW - 1))) m_dir = 1;
                  end else begin
                     m_leds = LW'(int'(m_leds) / 2);
                     if (m_leds % 2 == 1) m_dir = 0;
                  end
               end
               2'd3: begin
                  m_phase = !m_phase;
                  m_leds = m_phase ? '0 : m_pattern;
               end
               default: ;
            endcase
         end
      end
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0: return {29'b0, m_mode, m_en};
         2'd1: return {8'b0, m_period};
         2'd2: return {22'b0, m_pattern};
         default: return {6'b0, m_leds, 13'b0, m_phase, m_dir, m_run};
      endcase
   endfunction

   initial begin
      mdl_reset();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) mdl_reset();
         else mdl_step();
      end
   end

   // Single compare process: every negedge, all outputs against the model.
   initial forever begin
      @(negedge clk);
      check("pio_chipselect", {31'b0, pio_chipselect}, {31'b0, m_strobe});
      check("pio_write_n", {31'b0, pio_write_n}, {31'b0, !m_strobe});
      check("pio_writedata", pio_writedata, {22'b0, m_leds});
      check("pio_address", {30'b0, pio_address}, 32'd0);
      check("running", {31'b0, running}, {31'b0, m_run});
      check("cfg_readdata", cfg_readdata, m_read(cfg_address));
   end

   // Strobe log for the hand-computed sequence checks.
   logic [LW-1:0] log_val[$];
   int            log_cyc[$];

   initial forever begin
      @(negedge clk);
      if (pio_chipselect && !reset) begin
         log_val.push_back(pio_writedata[LW-1:0]);
         log_cyc.push_back(cyc);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach its end, cycle %0d", cyc);
      $fatal(1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
      cfg_address = a;
      cfg_writedata = d;
      cfg_chipselect = 1'b1;
      cfg_write_n = 1'b0;
      step(1);
      cfg_chipselect = 1'b0;
      cfg_write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      cfg_address = a;
      #1;
      d = cfg_readdata;
   endtask

   task automatic clear_log();
      log_val.delete();
      log_cyc.delete();
   endtask

   task automatic check_log(input string name, input int idx, input logic [LW-1:0] v,
                            input int c);
      if (idx < log_val.size()) begin
         check({name, " value"}, {22'b0, log_val[idx]}, {22'b0, v});
         check({name, " cycle"}, log_cyc[idx], c);
      end
   endtask

   task automatic check_reset_regs(input string tag);
      logic [31:0] d;
      rd(2'd1, d); check({tag, " PERIOD"}, d, 32'd5000000);
      rd(2'd2, d); check({tag, " PATTERN"}, d, 32'd1);
      rd(2'd3, d); check({tag, " STATUS"}, d, 32'd0);
      rd(2'd0, d); check({tag, " CTRL"}, d, 32'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [31:0] d;
      int e0;
      int n0;
      int r;
      logic [31:0] wd;

      step(3);
      reset = 1'b0;

      // 1: reset state, STATUS write ignored, no strobes while idle
      check_reset_regs("rst");
      cfg_wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd3, d); check("status write ignored", d, 32'd0);
      clear_log();
      step(100);
      check("idle strobes", log_val.size(), 0);

      // 2: rotate, period 4
      cfg_wr(2'd1, 32'd4);
      cfg_wr(2'd2, 32'h001);
      clear_log();
      cfg_wr(2'd0, 32'd3);
      e0 = cyc;
      step(4 * 11 + 2);
      check("rotate count", {31'b0, log_val.size() >= 12}, 32'd1);
      for (int i = 0; i < 11; i++)
         check_log("rotate", i, (i == 10) ? LW'(1) : LW'(1 << i), e0 + 4 * i);

      // 3: bounce, period 2
      cfg_wr(2'd0, 32'd0);
      cfg_wr(2'd1, 32'd2);
      cfg_wr(2'd2, 32'h001);
      clear_log();
      cfg_wr(2'd0, 32'd5);
      e0 = cyc;
      cfg_address = 2'd3;
      for (int k = 0; k < 100 && log_val.size() < 10; k++) step(1);
      #1;
      check("bounce dir after 0x200", {31'b0, cfg_readdata[1]}, 32'd1);
      check("bounce cur after 0x200", {22'b0, cfg_readdata[16 +: LW]}, 32'h200);
      step(45 - (cyc - e0));
      for (int i = 0; i < 20; i++) begin
         if (i < 10) check_log("bounce", i, LW'(1 << i), e0 + 2 * i);
         else if (i < 19) check_log("bounce", i, LW'(1 << (18 - i)), e0 + 2 * i);
         else check_log("bounce", i, LW'(2), e0 + 2 * i);
      end
      check("bounce count", {31'b0, log_val.size() >= 20}, 32'd1);

      // 4: blink, period 3
      cfg_wr(2'd0, 32'd0);
      cfg_wr(2'd1, 32'd3);
      cfg_wr(2'd2, 32'h2AA);
      clear_log();
      cfg_wr(2'd0, 32'd7);
      e0 = cyc;
      step(11);
      check("blink count", log_val.size(), 4);
      check_log("blink", 0, 10'h2AA, e0);
      check_log("blink", 1, 10'h000, e0 + 3);
      check_log("blink", 2, 10'h2AA, e0 + 6);
      check_log("blink", 3, 10'h000, e0 + 9);

      // 5: PATTERN write on a tick edge restarts; CTRL=0 stops
      cfg_wr(2'd0, 32'd0);
      cfg_wr(2'd1, 32'd4);
      cfg_wr(2'd2, 32'h001);
      clear_log();
      cfg_wr(2'd0, 32'd3);
      e0 = cyc;
      step(7);
      cfg_wr(2'd2, 32'h00F);
      step(6);
      check("restart count", log_val.size(), 4);
      check_log("restart", 0, 10'h001, e0);
      check_log("restart", 1, 10'h002, e0 + 4);
      check_log("restart", 2, 10'h00F, e0 + 8);
      check_log("restart", 3, 10'h01E, e0 + 12);
      cfg_wr(2'd0, 32'd0);
      n0 = log_val.size();
      step(20);
      check("stopped strobes", log_val.size(), n0);
      rd(2'd3, d); check("stopped status", d, 32'h001E_0000);

      // 6: async reset during a strobe, then PERIOD=0
      cfg_wr(2'd1, 32'd1);
      cfg_wr(2'd0, 32'd3);
      step(3);
      check("strobe before reset", {31'b0, pio_chipselect}, 32'd1);
      reset = 1'b1;
      #1;
      check("async cs drop", {31'b0, pio_chipselect}, 32'd0);
      check("async write_n", {31'b0, pio_write_n}, 32'd1);
      check("async running drop", {31'b0, running}, 32'd0);
      step(2);
      reset = 1'b0;
      check_reset_regs("post-reset");
      cfg_wr(2'd1, 32'd0);
      clear_log();
      cfg_wr(2'd0, 32'd3);
      e0 = cyc;
      step(12);
      for (int i = 0; i < 11; i++)
         check_log("period0", i, (i == 10) ? LW'(1) : LW'(1 << i), e0 + i);
      check("period0 count", {31'b0, log_val.size() >= 11}, 32'd1);

      // Random traffic against the model
      cfg_wr(2'd1, 32'd3);
      cfg_wr(2'd0, 32'd3);
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 99);
         cfg_address = 2'($urandom_range(0, 3));
         wd = $urandom;
         cfg_chipselect = 1'b0;
         cfg_write_n = 1'b1;
         if (r < 8) begin
            cfg_address = 2'($urandom_range(0, 2));
            if (cfg_address == 2'd1) wd[23:0] = 24'($urandom_range(0, 6));
            if (cfg_address == 2'd0) wd[0] = ($urandom_range(0, 3) != 0);
            cfg_chipselect = 1'b1;
            cfg_write_n = 1'b0;
         end else if (r < 12) begin
            cfg_chipselect = 1'b1;
         end else if (r < 14) begin
            cfg_write_n = 1'b0;
         end
         cfg_writedata = wd;
         if (r == 99 && $urandom_range(0, 4) == 0) reset = 1'b1;
         step(1);
         reset = 1'b0;
      end
      cfg_chipselect = 1'b0;
      cfg_write_n = 1'b1;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
